// File: rtl/saph_pkg.sv
// Shared definitions for the handshaked pipeline register (saph_plr_hs).
//   skid_state_e  : fill state of one 2-entry skid stage
//   saph_clog2p1  : number of bits needed to hold any value in 0..n (minimum 1)
package saph_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_HALF  = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

    function automatic int saph_clog2p1(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) <= n) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/saph_skid.sv
// One 2-entry skid-buffer stage: main register feeds downstream, skid register
// absorbs the item that arrives in the cycle the downstream stalls.
// Both handshake outputs are decoded straight from the state register, so
// there is no combinational path from dn_ready_i to up_ready_o.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   up_valid_i/up_ready_o/up_data_i upstream side
//   dn_valid_o/dn_ready_i/dn_data_o downstream side
//
// state      | meaning
// -----------+------------------------------------------------
// SKID_EMPTY | main and skid empty
// SKID_HALF  | main holds an item, skid empty
// SKID_FULL  | main and skid both hold an item, upstream stalled
module saph_skid
    import saph_pkg::*;
#(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [width-1:0] up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic [width-1:0] dn_data_o
);

    skid_state_e      state_q, state_d;
    logic [width-1:0] m_q, m_d;
    logic [width-1:0] s_q, s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            SKID_EMPTY: begin
                if (up_valid_i) begin
                    m_d     = up_data_i;
                    state_d = SKID_HALF;
                end
            end
            SKID_HALF: begin
                case ({dn_ready_i, up_valid_i})
                    2'b11: m_d = up_data_i;
                    2'b10: state_d = SKID_EMPTY;
                    2'b01: begin
                        s_d     = up_data_i;
                        state_d = SKID_FULL;
                    end
                    default: ;
                endcase
            end
            SKID_FULL: begin
                // Upstream is not ready here, so only a drain from skid to main is possible.
                if (dn_ready_i) begin
                    m_d     = s_q;
                    state_d = SKID_HALF;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    assign up_ready_o = (state_q != SKID_FULL);
    assign dn_valid_o = (state_q != SKID_EMPTY);
    assign dn_data_o  = m_q;

endmodule

// File: rtl/saph_plr_hs.sv
// Handshaked pipeline register: `latency` chained skid stages, each registering
// both data (forward) and ready (backward). latency=0 is a pure pass-through.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready/in_data       upstream side
//   out_valid/out_ready/out_data    downstream side
//   occupancy                       items in flight (only with SAPH_PLR_HS_OCC_EN)
//
// Optional feature macro: SAPH_PLR_HS_OCC_EN adds the occupancy counter and port.
module saph_plr_hs
    import saph_pkg::*;
#(
    parameter int width   = 1,
    parameter int latency = 1,
    localparam int OCC_W  = saph_clog2p1(2 * latency)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SAPH_PLR_HS_OCC_EN
    output logic [OCC_W-1:0] occupancy,
`endif
    output logic [width-1:0] out_data
);

    generate
        if (latency == 0) begin : g_pass
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
`ifdef SAPH_PLR_HS_OCC_EN
            assign occupancy = '0;
`endif
        end else begin : g_pipe
            // Index k is the link feeding stage k; index latency is the output link.
            logic [latency:0] vld;
            logic [latency:0] rdy;
            logic [width-1:0] dat [latency+1];

            assign vld[0]       = in_valid;
            assign dat[0]       = in_data;
            assign in_ready     = rdy[0];
            assign rdy[latency] = out_ready;
            assign out_valid    = vld[latency];
            assign out_data     = dat[latency];

            for (genvar k = 0; k < latency; k++) begin : g_stage
                saph_skid #(
                    .width(width)
                ) u_stage (
                    .clk       (clk),
                    .rst       (rst),
                    .up_valid_i(vld[k]),
                    .up_ready_o(rdy[k]),
                    .up_data_i (dat[k]),
                    .dn_valid_o(vld[k+1]),
                    .dn_ready_i(rdy[k+1]),
                    .dn_data_o (dat[k+1])
                );
            end

`ifdef SAPH_PLR_HS_OCC_EN
            localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 * latency);

            logic             in_xfer;
            logic             out_xfer;
            logic [OCC_W-1:0] occ_q, occ_d;

            assign in_xfer  = in_valid & rdy[0];
            assign out_xfer = vld[latency] & out_ready;

            always_comb begin
                occ_d = occ_q;
                if (in_xfer && !out_xfer && occ_q != OCC_MAX) begin
                    occ_d = occ_q + 1'b1;
                end else if (out_xfer && !in_xfer && occ_q != '0) begin
                    occ_d = occ_q - 1'b1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= occ_d;
                    // The skid structure makes these unreachable; firing means the
                    // counter and the stages disagree about what is in flight.
                    assert (!(in_xfer && !out_xfer && occ_q == OCC_MAX))
                        else $error("saph_plr_hs: occupancy overflow attempted");
                    assert (!(out_xfer && !in_xfer && occ_q == '0))
                        else $error("saph_plr_hs: occupancy underflow attempted");
                end
            end

            assign occupancy = occ_q;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_saph_plr_hs.sv
// Self-checking bench for saph_plr_hs: directed latency/capacity/reset tests,
// random valid/ready traffic against a queue reference, pass-through, and
// (with SAPH_PLR_HS_OCC_EN) occupancy tracking.
module tb_saph_plr_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // latency 3
    logic       rst3, iv3, ir3, ov3, or3;
    logic [7:0] id3, od3;
    // latency 2
    logic       rst2, iv2, ir2, ov2, or2;
    logic [7:0] id2, od2;
    // latency 0
    logic       rst0, iv0, ir0, ov0, or0;
    logic [7:0] id0, od0;
`ifdef SAPH_PLR_HS_OCC_EN
    logic [2:0] occ3, occ2;
    logic       occ0;
`endif

    saph_plr_hs #(.width(8), .latency(3)) u_l3 (
        .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3),
`ifdef SAPH_PLR_HS_OCC_EN
        .occupancy(occ3),
`endif
        .out_data(od3));

    saph_plr_hs #(.width(8), .latency(2)) u_l2 (
        .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2),
`ifdef SAPH_PLR_HS_OCC_EN
        .occupancy(occ2),
`endif
        .out_data(od2));

    saph_plr_hs #(.width(8), .latency(0)) u_l0 (
        .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0),
`ifdef SAPH_PLR_HS_OCC_EN
        .occupancy(occ0),
`endif
        .out_data(od0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0]  ref_q[$];
        logic [7:0]  prev_d;
        logic [31:0] exp_d;
        logic        stall_prev;
        logic        acc;
        int          cnt;
`ifdef SAPH_PLR_HS_OCC_EN
        int          occ_m;
        int          occ_pre;
        logic        both;
        logic        found;
`endif

        rst3 = 1'b1; rst2 = 1'b1; rst0 = 1'b1;
        iv3 = 0; id3 = 0; or3 = 0;
        iv2 = 0; id2 = 0; or2 = 0;
        iv0 = 0; id0 = 0; or0 = 0;
        #2;
        chk("rst l3 out_valid", ov3, 0);
        chk("rst l3 out_data", od3, 0);
        chk("rst l3 in_ready", ir3, 1);
        chk("rst l2 out_valid", ov2, 0);
        chk("rst l2 in_ready", ir2, 1);
`ifdef SAPH_PLR_HS_OCC_EN
        chk("rst l3 occupancy", occ3, 0);
        chk("rst l2 occupancy", occ2, 0);
`endif
        rst3 = 1'b0; rst2 = 1'b0; rst0 = 1'b0;
        tick();

        // Latency 3, downstream always ready: three back-to-back items.
        or3 = 1; iv3 = 1; id3 = 8'h11;
        chk("lat in_ready", ir3, 1);
        tick();
        id3 = 8'h22;
        chk("lat early1 out_valid", ov3, 0);
        tick();
        id3 = 8'h33;
        chk("lat early2 out_valid", ov3, 0);
        tick();
        iv3 = 0;
        chk("lat item0", {ov3, od3}, {1'b1, 8'h11});
        tick();
        chk("lat item1", {ov3, od3}, {1'b1, 8'h22});
        tick();
        chk("lat item2", {ov3, od3}, {1'b1, 8'h33});
        tick();
        chk("lat empty", ov3, 0);

        // Latency 3 capacity: downstream stalled, push incrementing bytes.
        or3 = 0; iv3 = 1; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            id3 = cnt[7:0];
            acc = ir3;
            tick();
            if (acc) cnt++;
        end
        chk("cap accepts", cnt, 6);
        chk("cap in_ready", ir3, 0);
        chk("cap head held", {ov3, od3}, {1'b1, 8'h00});
        iv3 = 0; or3 = 1;
        for (int k = 0; k < 6; k++) begin
            chk("cap drain", {ov3, od3}, {1'b1, 8'(k)});
            tick();
        end
        chk("cap drained", ov3, 0);

        // Latency 2 random traffic against a FIFO reference.
        stall_prev = 0; prev_d = 0;
        for (int i = 0; i < 1000; i++) begin
            if (stall_prev) chk("rnd hold", {ov2, od2}, {1'b1, prev_d});
            iv2 = 1'($urandom_range(0, 1));
            id2 = 8'($urandom);
            or2 = 1'($urandom_range(0, 1));
            if (ov2 && or2) begin
                exp_d = (ref_q.size() != 0) ? {24'b0, ref_q.pop_front()} : 'x;
                chk("rnd order", {24'b0, od2}, exp_d);
            end
            if (iv2 && ir2) ref_q.push_back(id2);
            chk("rnd capacity", ref_q.size() <= 4, 1);
            stall_prev = ov2 && !or2;
            prev_d     = od2;
            tick();
        end
        iv2 = 0; or2 = 1;
        for (int i = 0; i < 20; i++) begin
            if (ov2) begin
                exp_d = (ref_q.size() != 0) ? {24'b0, ref_q.pop_front()} : 'x;
                chk("rnd drain order", {24'b0, od2}, exp_d);
            end
            tick();
        end
        chk("rnd lost items", ref_q.size(), 0);
        chk("rnd drained", ov2, 0);

        // Latency 2 asynchronous reset with three items in flight.
        or2 = 0; iv2 = 1;
        for (int i = 0; i < 3; i++) begin
            id2 = 8'(8'hA0 + i);
            tick();
        end
        iv2 = 0;
        chk("pre-rst out_valid", ov2, 1);
        #3 rst2 = 1'b1;
        #1;
        chk("async rst out_valid", ov2, 0);
        chk("async rst in_ready", ir2, 1);
        chk("async rst out_data", od2, 0);
`ifdef SAPH_PLR_HS_OCC_EN
        chk("async rst occupancy", occ2, 0);
`endif
        #1 rst2 = 1'b0;
        or2 = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post-rst no emit", ov2, 0);
        end

        // Latency 0 pass-through.
        for (int i = 0; i < 8; i++) begin
            iv0 = 1'($urandom_range(0, 1));
            or0 = 1'($urandom_range(0, 1));
            id0 = 8'($urandom);
            #1;
            chk("pass in_ready", ir0, or0);
            chk("pass out_valid", ov0, iv0);
            chk("pass out_data", od0, id0);
        end

`ifdef SAPH_PLR_HS_OCC_EN
        // Occupancy on latency 2.
        occ_m = 0;
        or2 = 0; iv2 = 1;
        for (int i = 0; i < 4; i++) begin
            id2 = 8'(i);
            if (iv2 && ir2) occ_m++;
            tick();
        end
        chk("occ full", occ2, 4);
        chk("occ full count", occ_m, 4);
        chk("occ full in_ready", ir2, 0);
        or2 = 1; found = 0;
        for (int i = 0; i < 10; i++) begin
            both    = ir2 && ov2;
            occ_pre = occ_m;
            occ_m   = occ_m + int'(iv2 && ir2) - int'(ov2 && or2);
            tick();
            chk("occ track", occ2, occ_m);
            if (both) begin
                chk("occ simultaneous", occ2, occ_pre);
                found = 1;
                break;
            end
        end
        if (!found) chk("occ simultaneous timeout", found, 1);
        iv2 = 0;
        for (int i = 0; i < 12; i++) begin
            occ_m = occ_m - int'(ov2 && or2);
            tick();
        end
        chk("occ drained", occ2, 0);
        chk("occ drained model", occ_m, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
